// File: rtl/traffic_light_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_light_controller: highway/farm-road sequencer with demand     |
// | sensing, maintenance flashing and a sticky timer watchdog.            |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module traffic_light_controller #(
  parameter int WDOG_CYCLES = 300,
  parameter int WDOG_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_sensor,
  input  logic       maint,
  input  logic       timer_done,
  output logic       start_long,
  output logic       start_short,
  output logic [2:0] hwy_light,
  output logic [2:0] farm_light,
  output logic       fault,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_HG    = 3'd0,
    S_HY    = 3'd1,
    S_FG    = 3'd2,
    S_FY    = 3'd3,
    S_MAINT = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [WDOG_W-1:0] c_wdog_limit = WDOG_W'(WDOG_CYCLES - 1);

  state_t            r_state;
  logic              r_busy;
  logic              r_started;
  logic              r_served;
  logic              r_blink;
  logic              r_fault;
  logic [WDOG_W-1:0] r_wdog;
  logic              r_start_long;
  logic              r_start_short;
  logic [2:0]        r_hwy;
  logic [2:0]        r_farm;

  state_t     w_state_nx;
  logic       w_blink_nx;
  logic       w_own_done;
  logic       w_busy_eff;
  logic       w_timeout;
  logic       w_chg;
  logic       w_go;
  logic       w_long;
  logic [2:0] w_hwy_nx;
  logic [2:0] w_farm_nx;

  function automatic logic f_timed(state_t s);
    return s inside {S_HG, S_HY, S_FG, S_FY, S_MAINT};
  endfunction

  always_comb begin
    w_state_nx = r_state;
    w_blink_nx = r_blink;
    w_hwy_nx   = 3'b100;
    w_farm_nx  = 3'b100;
    // r_started separates the current state's own timer from one still
    // running on behalf of the state we just left.
    w_own_done = timer_done & r_busy & r_started;
    w_busy_eff = r_busy & ~timer_done;
    w_timeout  = r_busy & (r_wdog == c_wdog_limit);

    if (r_fault) begin
      w_state_nx = S_FAULT;
    end else if (maint && (r_state != S_MAINT) && (r_state != S_FAULT)) begin
      w_state_nx = S_MAINT;
    end else begin
      case (r_state)
        S_HG:    if (r_served && car_sensor) w_state_nx = S_HY;
        S_HY:    if (w_own_done) w_state_nx = S_FG;
        S_FG:    if (w_own_done) w_state_nx = S_FY;
        S_FY:    if (w_own_done) w_state_nx = S_HG;
        S_MAINT: begin
          if (w_own_done) begin
            w_blink_nx = ~r_blink;
            if (!maint) w_state_nx = S_HY;
          end
        end
        default: w_state_nx = S_FAULT;
      endcase
    end

    w_chg = (w_state_nx != r_state);
    if (w_chg)
      w_go = f_timed(w_state_nx) & ~w_busy_eff;
    else if ((r_state == S_MAINT) && w_own_done)
      w_go = 1'b1;
    else
      w_go = f_timed(r_state) & ~r_started & ~r_busy;
    w_long = (w_state_nx == S_HG) || (w_state_nx == S_FG);

    case (w_state_nx)
      S_HG:    begin w_hwy_nx = 3'b001; w_farm_nx = 3'b100; end
      S_HY:    begin w_hwy_nx = 3'b010; w_farm_nx = 3'b100; end
      S_FG:    begin w_hwy_nx = 3'b100; w_farm_nx = 3'b001; end
      S_FY:    begin w_hwy_nx = 3'b100; w_farm_nx = 3'b010; end
      S_MAINT: begin
        w_hwy_nx  = w_blink_nx ? 3'b010 : 3'b000;
        w_farm_nx = w_blink_nx ? 3'b010 : 3'b000;
      end
      default: begin w_hwy_nx = 3'b100; w_farm_nx = 3'b100; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_HG;
      r_busy        <= 1'b0;
      r_started     <= 1'b0;
      r_served      <= 1'b0;
      r_blink       <= 1'b0;
      r_fault       <= 1'b0;
      r_wdog        <= '0;
      r_start_long  <= 1'b0;
      r_start_short <= 1'b0;
      r_hwy         <= 3'b001;
      r_farm        <= 3'b100;
    end else begin
      r_state       <= w_state_nx;
      r_blink       <= w_blink_nx;
      r_start_long  <= w_go & w_long;
      r_start_short <= w_go & ~w_long;
      r_started     <= w_chg ? w_go : (r_started | w_go);
      r_busy        <= w_go ? 1'b1 : (timer_done ? 1'b0 : r_busy);
      r_served      <= w_chg ? 1'b0 : (r_served | w_own_done);
      r_wdog        <= w_go ? '0 : (r_busy ? r_wdog + WDOG_W'(1) : r_wdog);
      r_fault       <= r_fault | w_timeout;
      r_hwy         <= w_hwy_nx;
      r_farm        <= w_farm_nx;
    end
  end

  assign start_long  = r_start_long;
  assign start_short = r_start_short;
  assign hwy_light   = r_hwy;
  assign farm_light  = r_farm;
  assign fault       = r_fault;
  assign state_dbg   = r_state;

endmodule
`default_nettype wire
